// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: serial input line and received-byte outputs of uart_rx_core.
interface uart_rx_core_if;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  modport master (output rx, input data_out, valid, frame_err);
  modport slave (input rx, output data_out, valid, frame_err);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver, LSB first, mid-bit sampling.
// Define UART_RX_FRAME_CHECK_EN to flag a zero stop bit on frame_err instead of delivering the byte.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434
) (
  input logic          clk,
  input logic          rst,
  uart_rx_core_if.slave u_if
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift, r_data;
  logic          r_rx1, r_rx2, r_valid, r_ferr;
  logic          w_half, w_full, w_clr, w_stop, w_load, w_ferr;
  assign w_half = r_cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign w_full = r_cnt == CW'(CLKS_PER_BIT - 1);
  assign w_clr  = r_state == IDLE || w_next != r_state || w_full;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb
    w_next = r_state == IDLE  ? (r_rx2 ? IDLE : START)
           : r_state == START ? (w_half ? (r_rx2 ? IDLE : DATA) : START)
           : r_state == DATA  ? ((w_full && r_idx == 3'd7) ? STOP : DATA)
           : (w_full ? IDLE : STOP);
  // Leaving STOP at mid stop bit lets a following start edge be caught on time.
  always_comb begin
    w_stop = r_state == STOP && w_full;
`ifdef UART_RX_FRAME_CHECK_EN
    w_load = w_stop && r_rx2;
    w_ferr = w_stop && !r_rx2;
`else
    w_load = w_stop;
    w_ferr = 1'b0;
`endif
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_rx1   <= 1'b1;
      r_rx2   <= 1'b1;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_rx1   <= u_if.rx;
      r_rx2   <= r_rx1;
      r_cnt   <= w_clr ? '0 : r_cnt + 1'b1;
      r_idx   <= r_state != DATA ? 3'd0 : r_idx + 3'(w_full);
      if (r_state == DATA && w_full) r_shift[r_idx] <= r_rx2;
      if (w_load) r_data <= r_shift;
      r_valid <= w_load;
      r_ferr  <= w_ferr;
    end
  assign u_if.data_out  = r_data;
  assign u_if.valid     = r_valid;
  assign u_if.frame_err = r_ferr;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and random 8N1 frames checked against a byte-level model.
module tb_uart_rx_core;
  localparam int CPB = 434;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         v_cyc[$];
  logic [7:0] v_dat[$];
  int         fe_tot = 0;
  int         v_rd = 0;
  int         fe_rd = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  uart_rx_core_if u_if();
  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .u_if(u_if.slave));
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (u_if.valid === 1'b1) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(u_if.data_out);
      chk("excl", {31'd0, u_if.frame_err}, 0);
      chk("vwidth", {31'd0, prev_valid}, 0);
    end
    if (u_if.frame_err === 1'b1) fe_tot <= fe_tot + 1;
    prev_valid <= u_if.valid;
  end
  task automatic send(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc;
    u_if.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    chk("hold", {24'd0, u_if.data_out}, {24'd0, m_data});
    u_if.rx = stop;
    repeat (CPB) @(negedge clk);
    u_if.rx = 1'b1;
  endtask
  task automatic expect_frame(input string tag, input logic [7:0] b, input logic stop, input int t0);
    bit ok;
    int lat;
`ifdef UART_RX_FRAME_CHECK_EN
    ok = stop;
`else
    ok = 1'b1;
`endif
    chk({tag, "_nvalid"}, v_dat.size() - v_rd, {31'd0, ok});
    chk({tag, "_nferr"}, fe_tot - fe_rd, {31'd0, !ok});
    if (ok) m_data = b;
    if (v_dat.size() > v_rd) begin
      chk({tag, "_data"}, {24'd0, v_dat[v_rd]}, {24'd0, b});
      lat = v_cyc[v_rd] - t0;
      chk({tag, "_lat"}, {31'd0, lat >= LAT - 2 && lat <= LAT + 2}, 1);
    end
    chk({tag, "_dout"}, {24'd0, u_if.data_out}, {24'd0, m_data});
    v_rd = v_dat.size();
    fe_rd = fe_tot;
  endtask
  task automatic quiet(input string tag);
    chk({tag, "_nvalid"}, v_dat.size() - v_rd, 0);
    chk({tag, "_nferr"}, fe_tot - fe_rd, 0);
    chk({tag, "_dout"}, {24'd0, u_if.data_out}, {24'd0, m_data});
    v_rd = v_dat.size();
    fe_rd = fe_tot;
  endtask
  initial begin
    int t0, t1;
    logic [7:0] b;
    logic stop;
    u_if.rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout", {24'd0, u_if.data_out}, 0);
    chk("rst_valid", {31'd0, u_if.valid}, 0);
    chk("rst_ferr", {31'd0, u_if.frame_err}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send(8'h41, 1'b1, t0);
    expect_frame("f41", 8'h41, 1'b1, t0);
    repeat (3) @(negedge clk);
    send(8'h35, 1'b1, t0);
    expect_frame("f35", 8'h35, 1'b1, t0);
    repeat (20) @(negedge clk);
    u_if.rx = 1'b0;
    repeat (5) @(negedge clk);
    u_if.rx = 1'b1;
    repeat (CPB) @(negedge clk);
    quiet("glitch");
    send(8'hA5, 1'b1, t0);
    expect_frame("fA5", 8'hA5, 1'b1, t0);
    send(8'h00, 1'b1, t0);
    expect_frame("b2b0", 8'h00, 1'b1, t0);
    send(8'hFF, 1'b1, t1);
    expect_frame("b2b1", 8'hFF, 1'b1, t1);
    repeat (10) @(negedge clk);
    send(8'h5A, 1'b0, t0);
    expect_frame("f5A", 8'h5A, 1'b0, t0);
    repeat (2 * CPB) @(negedge clk);
    quiet("post5A");
    b = 8'hC3;
    u_if.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      u_if.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    u_if.rx = b[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    m_data = 8'h00;
    chk("mrst_dout", {24'd0, u_if.data_out}, 0);
    chk("mrst_valid", {31'd0, u_if.valid}, 0);
    chk("mrst_ferr", {31'd0, u_if.frame_err}, 0);
    rst = 1'b0;
    u_if.rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    quiet("abort");
    send(8'h3C, 1'b1, t0);
    expect_frame("f3C", 8'h3C, 1'b1, t0);
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      stop = $urandom_range(0, 3) != 0;
      repeat ($urandom_range(1, 20)) @(negedge clk);
      send(b, stop, t0);
      expect_frame("rnd", b, stop, t0);
      if (!stop) repeat (2 * CPB) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    quiet("end");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
